// File: rtl/segre_mem_arbiter.sv
// Shares the single main-memory port between the I-cache and D-cache.
// IC has priority; a starvation counter forces a DC win after STARVE_LIMIT contested IC wins.
module segre_mem_arbiter #(
   parameter int ADDR_WIDTH   = 32,
   parameter int LINE_WIDTH   = 128,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  ic_req_i,
   input  logic [ADDR_WIDTH-1:0] ic_addr_i,
   output logic                  ic_valid_o,
   output logic [LINE_WIDTH-1:0] ic_rdata_o,
   input  logic                  dc_req_i,
   input  logic                  dc_we_i,
   input  logic [ADDR_WIDTH-1:0] dc_addr_i,
   input  logic [LINE_WIDTH-1:0] dc_wdata_i,
   output logic                  dc_valid_o,
   output logic [LINE_WIDTH-1:0] dc_rdata_o,
   output logic                  mem_req_o,
   output logic                  mem_we_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [LINE_WIDTH-1:0] mem_wdata_o,
   input  logic                  mem_ack_i,
   input  logic [LINE_WIDTH-1:0] mem_rdata_i,
   output logic                  sel_mem_req_o,
   output logic                  busy_o
);

   // state | meaning
   // IDLE  | no transaction; arbitrate and latch the winner
   // BUSY  | request held toward memory until mem_ack_i
   // RESP  | one-cycle valid pulse to the owner
   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   localparam int CW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);

   state_t          state, state_nxt;
   logic            owner;
   logic [CW-1:0]   starve_cnt;
   logic            grant, grant_dc;
   logic            we_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [LINE_WIDTH-1:0] wdata_q;
   logic [LINE_WIDTH-1:0] ic_rdata_q, dc_rdata_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      grant     = 1'b0;
      grant_dc  = 1'b0;
      case (state)
         IDLE: begin
            if (ic_req_i || dc_req_i) begin
               grant     = 1'b1;
               state_nxt = BUSY;
               if (!ic_req_i)
                  grant_dc = 1'b1;
               else if (dc_req_i && (starve_cnt == STARVE_MAX))
                  grant_dc = 1'b1;
            end
         end
         BUSY:    if (mem_ack_i) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Winner fields are latched once in IDLE and held stable for all of BUSY.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         owner      <= 1'b0;
         starve_cnt <= '0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
      end else if (grant) begin
         owner   <= grant_dc;
         addr_q  <= grant_dc ? dc_addr_i : ic_addr_i;
         we_q    <= grant_dc & dc_we_i;
         wdata_q <= (grant_dc && dc_we_i) ? dc_wdata_i : '0;
         if (grant_dc)
            starve_cnt <= '0;
         else if (dc_req_i && (starve_cnt != STARVE_MAX))
            starve_cnt <= starve_cnt + CW'(1);
      end
   end

   // A DC write-back leaves dc_rdata untouched.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ic_rdata_q <= '0;
         dc_rdata_q <= '0;
      end else if ((state == BUSY) && mem_ack_i) begin
         if (!owner)     ic_rdata_q <= mem_rdata_i;
         else if (!we_q) dc_rdata_q <= mem_rdata_i;
      end
   end

   assign mem_req_o     = (state == BUSY);
   assign busy_o        = (state != IDLE);
   assign sel_mem_req_o = owner;
   assign mem_we_o      = we_q;
   assign mem_addr_o    = addr_q;
   assign mem_wdata_o   = wdata_q;
   assign ic_valid_o    = (state == RESP) && !owner;
   assign dc_valid_o    = (state == RESP) && owner;
   assign ic_rdata_o    = ic_rdata_q;
   assign dc_rdata_o    = dc_rdata_q;

endmodule
